// File: rtl/aska_spi_pkg.sv
// Shared constants, FSM state type and counter sizing for the ASKA SPI register file.
// Pure declarations; no logic, no latency.
package aska_spi_pkg;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Counter must reach 8+M+1 (saturation value) without wrapping.
  function automatic int bcnt_width(input int m);
    return $clog2(CMD_W + m + 2);
  endfunction

endpackage

// File: rtl/aska_spi_regfile_sync_edge.sv
// 2-FF synchroniser with registered rise/fall pulses for one asynchronous SPI pin.
// Pulse appears 3 clk cycles after the pin edge; no backpressure.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, prev_q, rise_q, fall_q;
  logic s1_d, s2_d, prev_d, rise_d, fall_d;

  always_comb begin
    s1_d   = d_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    rise_d = s2_q & ~prev_q;
    fall_d = ~s2_q & prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/aska_spi_regfile.sv
// Oversampled mode-0 SPI slave holding NREG x M configuration registers with read-back.
// Commit/error 4 clk after CS rising pin edge; MISO valid 4 clk after SCK falling; no backpressure.
module aska_spi_regfile
  import aska_spi_pkg::*;
#(
  parameter int M    = 32,
  parameter int NREG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPI_CS,
  input  logic              SPI_Clk,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [NREG*M-1:0] regs,
  output logic [NREG-1:0]   wr_strobe,
  output logic              frame_err
);

  localparam int BW = bcnt_width(M);
  localparam logic [BW-1:0] BCNT_CMD  = BW'(CMD_W);
  localparam logic [BW-1:0] BCNT_FULL = BW'(CMD_W + M);
  localparam logic [BW-1:0] BCNT_MAX  = BW'(CMD_W + M + 1);
  localparam logic [BW-1:0] TX_FIRST  = BW'(CMD_W + 1);
  localparam logic [BW-1:0] TX_LAST   = BW'(CMD_W + M - 1);

  logic cs_rise, cs_fall, sck_rise, sck_fall;

  // CS idles high, so its synchroniser resets high to avoid a phantom edge.
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (SPI_CS),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (SPI_Clk),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  logic mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;

  always_comb begin
    mosi_s1_d = SPI_MOSI;
    mosi_s2_d = mosi_s1_q;
  end

  state_e            state_q, state_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [M-1:0]      rx_shift_q, rx_shift_d;
  logic [M-1:0]      tx_shift_q, tx_shift_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [M-1:0]      regs_q [NREG];
  logic [M-1:0]      regs_d [NREG];
  logic [NREG-1:0]   wr_strobe_q, wr_strobe_d;
  logic              frame_err_q, frame_err_d;

  logic [6:0]        new_addr;
  logic [M-1:0]      rd_word;
  logic              addr_ok;
  logic              frame_ok;

  // Address of the command completing on this SCK edge, used to preload the read word.
  always_comb begin
    new_addr = {rx_shift_q[5:0], mosi_s2_q};
    rd_word  = '0;
    for (int k = 0; k < NREG; k++) begin
      if (new_addr == 7'(k)) rd_word = regs_q[k];
    end
  end

  always_comb begin
    addr_ok  = ({1'b0, cmd_q[6:0]} < 8'(NREG));
    frame_ok = (bcnt_q == BCNT_FULL) && addr_ok;
  end

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    cmd_d       = cmd_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;

    if (cs_rise) begin
      // An empty CS pulse ends silently; anything else commits or errors.
      if (state_q != IDLE && bcnt_q != '0) begin
        if (!frame_ok) begin
          frame_err_d = 1'b1;
        end else if (!cmd_q[RW_BIT]) begin
          for (int k = 0; k < NREG; k++) begin
            if (cmd_q[6:0] == 7'(k)) begin
              regs_d[k]      = rx_shift_q;
              wr_strobe_d[k] = 1'b1;
            end
          end
        end
      end
      state_d = IDLE;
    end else if (cs_fall) begin
      state_d    = CMD;
      bcnt_d     = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      cmd_d      = '0;
    end else if (state_q != IDLE) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[M-2:0], mosi_s2_q};
        if (bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == BCNT_CMD - BW'(1)) begin
          cmd_d      = {rx_shift_q[CMD_W-2:0], mosi_s2_q};
          state_d    = DATA;
          tx_shift_d = cmd_d[RW_BIT] ? rd_word : '0;
        end
      end else if (sck_fall && state_q == DATA &&
                   bcnt_q >= TX_FIRST && bcnt_q <= TX_LAST) begin
        tx_shift_d = {tx_shift_q[M-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= IDLE;
      bcnt_q      <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      cmd_q       <= '0;
      regs_q      <= '{default: '0};
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      cmd_q       <= cmd_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    regs = '0;
    for (int k = 0; k < NREG; k++) begin
      regs[k*M +: M] = regs_q[k];
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
  assign SPI_MISO  = (state_q == DATA) && cmd_q[RW_BIT] && tx_shift_q[M-1];

endmodule

// File: tb/tb_aska_spi_regfile.sv
// Directed bench for aska_spi_regfile: one 32x4 instance and one 16x8 instance sharing SCK/MOSI.
// Each instance has its own chip select; pulses are counted continuously.
module tb_aska_spi_regfile;

  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cs_a = 1'b1, cs_b = 1'b1;
  logic         sck = 1'b0, mosi = 1'b0;
  logic         miso_a, miso_b;
  logic [127:0] regs_a;
  logic [127:0] regs_b;
  logic [3:0]   strb_a;
  logic [7:0]   strb_b;
  logic         ferr_a, ferr_b;

  int n_checks = 0;
  int n_errors = 0;
  int sa_cnt [4];
  int sb_cnt [8];
  int fa_cnt = 0, fb_cnt = 0;

  logic [63:0]  rd;
  logic [127:0] snap;

  always #5 clk = ~clk;

  aska_spi_regfile #(.M(32), .NREG(4)) dut_a (
    .clk(clk), .reset(reset), .SPI_CS(cs_a), .SPI_Clk(sck), .SPI_MOSI(mosi),
    .SPI_MISO(miso_a), .regs(regs_a), .wr_strobe(strb_a), .frame_err(ferr_a)
  );

  aska_spi_regfile #(.M(16), .NREG(8)) dut_b (
    .clk(clk), .reset(reset), .SPI_CS(cs_b), .SPI_Clk(sck), .SPI_MOSI(mosi),
    .SPI_MISO(miso_b), .regs(regs_b), .wr_strobe(strb_b), .frame_err(ferr_b)
  );

  initial begin
    for (int k = 0; k < 4; k++) sa_cnt[k] = 0;
    for (int k = 0; k < 8; k++) sb_cnt[k] = 0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (strb_a[k]) sa_cnt[k]++;
    for (int k = 0; k < 8; k++) if (strb_b[k]) sb_cnt[k]++;
    if (ferr_a) fa_cnt++;
    if (ferr_b) fb_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sa_total();
    return sa_cnt[0] + sa_cnt[1] + sa_cnt[2] + sa_cnt[3];
  endfunction

  // Sends cmd then the low ndata bits of data, MSB first; MISO captured just before each data SCK rise.
  task automatic spi_xfer(input bit sel, input logic [7:0] cmd, input logic [63:0] data,
                          input int ndata, input bit do_end, output logic [63:0] rdata);
    rdata = '0;
    @(negedge clk);
    if (sel) cs_b = 1'b0; else cs_a = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8 + ndata; i++) begin
      mosi = (i < 8) ? cmd[7-i] : data[ndata-1-(i-8)];
      repeat (HALF) @(negedge clk);
      if (i >= 8) rdata = {rdata[62:0], (sel ? miso_b : miso_a)};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (do_end) begin
      cs_a = 1'b1;
      cs_b = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    check("reset_regs", regs_a, '0);
    check("reset_strobe", strb_a, '0);
    check("reset_ferr", ferr_a, 1'b0);
    check("reset_miso", miso_a, 1'b0);

    spi_xfer(0, 8'h00, 64'hAABBCCDD, 32, 1, rd);
    check("wr0", regs_a[31:0], 32'hAABBCCDD);
    spi_xfer(0, 8'h01, 64'h3377EEFF, 32, 1, rd);
    check("wr1", regs_a[63:32], 32'h3377EEFF);
    spi_xfer(0, 8'h02, 64'hBEBECACA, 32, 1, rd);
    check("wr2", regs_a[95:64], 32'hBEBECACA);
    spi_xfer(0, 8'h03, 64'hCAFEBABA, 32, 1, rd);
    check("wr3", regs_a[127:96], 32'hCAFEBABA);
    check("strobes_per_reg", {sa_cnt[3][7:0], sa_cnt[2][7:0], sa_cnt[1][7:0], sa_cnt[0][7:0]},
          32'h01010101);
    check("no_ferr_writes", fa_cnt, 0);

    spi_xfer(0, 8'h03, 64'h00112233, 24, 1, rd);
    check("short_ferr", fa_cnt, 1);
    check("short_reg3", regs_a[127:96], 32'hCAFEBABA);
    check("short_nostrobe", sa_total(), 4);

    spi_xfer(0, 8'h01, 64'h1_2345_6789, 33, 1, rd);
    check("long_ferr", fa_cnt, 2);
    check("long_reg1", regs_a[63:32], 32'h3377EEFF);

    snap = regs_a;
    spi_xfer(0, 8'h81, 64'hFFFFFFFF, 32, 1, rd);
    check("read1_data", rd[31:0], 32'h3377EEFF);
    check("read1_regs", regs_a, snap);
    check("read1_ferr", fa_cnt, 2);
    check("read1_nostrobe", sa_total(), 4);

    spi_xfer(0, 8'h05, 64'h55555555, 32, 1, rd);
    check("oob_wr_ferr", fa_cnt, 3);
    check("oob_wr_regs", regs_a, snap);
    spi_xfer(0, 8'h85, 64'h0, 32, 1, rd);
    check("oob_rd_data", rd[31:0], 32'h0);
    check("oob_rd_ferr", fa_cnt, 4);

    spi_xfer(0, 8'h00, 64'h000ABCDE, 12, 0, rd);
    reset = 1'b1;
    cs_a = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_regs", regs_a, '0);
    check("rst_nostrobe", sa_total(), 4);
    check("rst_noferr", fa_cnt, 4);

    spi_xfer(0, 8'h02, 64'h0BADF00D, 32, 1, rd);
    check("post_rst_wr", regs_a, {32'h0, 32'h0BADF00D, 32'h0, 32'h0});
    check("post_rst_strobe", sa_cnt[2], 2);

    spi_xfer(1, 8'h07, 64'h1234, 16, 1, rd);
    check("b_wr7", regs_b[127:112], 16'h1234);
    check("b_strobe7", sb_cnt[7], 1);
    spi_xfer(1, 8'h87, 64'h0, 16, 1, rd);
    check("b_rd7", rd[15:0], 16'h1234);
    check("b_noferr", fb_cnt, 0);
    check("a_untouched_by_b", regs_a, {32'h0, 32'h0BADF00D, 32'h0, 32'h0});

    snap = regs_b;
    spi_xfer(1, 8'h00, 64'h0, -8, 1, rd);
    check("b_empty_ferr", fb_cnt, 0);
    check("b_empty_regs", regs_b, snap);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aska_spi_regfile.md
# aska_spi_regfile

Parametrised successor to the ASKA SPI configuration slave. Holds `NREG` registers of `M` bits, written and now also read back over a mode-0 SPI link. SPI pins are oversampled in the system clock domain. Frames that are incomplete, over-length or out of range are rejected with an error pulse. Register outputs feed the analog front-end configuration and electrode-select logic.

## Interface
Parameters:
- `M`, 32: register width in bits; must be a multiple of 8, range 8..64.
- `NREG`, 4: number of registers, range 1..128.

Ports:
- `clk`  in  1: system clock; must be at least 8× the `SPI_Clk` frequency.
- `reset`  in  1: synchronous, active-high reset.
- `SPI_CS`  in  1: chip select, active low, asynchronous to `clk`.
- `SPI_Clk`  in  1: SPI clock, CPOL=0/CPHA=0, asynchronous.
- `SPI_MOSI`  in  1: serial data in, MSB first.
- `SPI_MISO`  out  1: serial data out, MSB first; driven 0 when not reading (no tri-state).
- `regs`  out  NREG*M: flat register bus; register k occupies `regs[k*M +: M]`.
- `wr_strobe`  out  NREG: one-cycle pulse on bit k when register k is committed.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected.

## Operation
- **Synchronisation:** `SPI_CS`, `SPI_Clk` and `SPI_MOSI` each pass through 2-FF synchronisers. Edge detection runs on the synchronised CS and SCK.
- **Frame format:** 8-bit command, then M data bits.
  - Command bit 7 = R/W (1 = read).
  - Command bits 6:0 = address.
- **States:**
  - IDLE: CS high.
  - CMD: on CS falling → clear bit counter `bcnt` and the shift register.
  - DATA: entered when `bcnt` reaches 8.
  - CMD/DATA → IDLE on CS rising.
- **Receive:** each SCK rising edge with CS low shifts MOSI into `rx_shift` and increments `bcnt`. `bcnt` saturates at 8+M+1.
- **Write commit:** at CS rising, if `bcnt == 8+M` and R/W=0 and `addr < NREG`:
  - `regs[addr] <= rx_shift[M-1:0]`
  - `wr_strobe[addr]` pulses.
- **Read:**
  - On the 8th SCK rising edge with R/W=1, `tx_shift` loads `regs[addr]`, or 0 if `addr >= NREG`.
  - `SPI_MISO` = `tx_shift[M-1]`.
  - `tx_shift` shifts left on SCK falling edges while `9 <= bcnt <= 8+M-1`.
  - A read frame never modifies `regs`.
- **Rejection:** at CS rising, `frame_err` pulses and nothing is committed if any of the following holds:
  - `bcnt != 8+M`
  - `addr >= NREG`
  - Exception: a CS low/high with `bcnt == 0` is silent — no error, no commit.
- SCK edges while CS is high are ignored.

## Timing
- Reset values:
  - `regs` = 0
  - `wr_strobe` = 0
  - `frame_err` = 0
  - `SPI_MISO` = 0
  - state = IDLE, `bcnt` = 0
- Pin-to-edge-detect latency: 3 `clk` cycles (2 sync stages + edge register).
- `regs`/`wr_strobe`/`frame_err` update in the cycle after the CS-rising detect, i.e. ≤4 `clk` cycles after the pin edge.
- `SPI_MISO` is valid ≤4 `clk` cycles after the SCK falling pin edge. This fits within the SCK low half-period at the 8× clock ratio.
- Simultaneous CS-rising and SCK-edge detects in the same cycle: CS wins and the SCK edge is discarded.
- `reset` mid-frame: return to IDLE, discard the frame, no strobe, no error; `regs` clear to 0.
- A CS falling edge seen while not in IDLE cannot occur; CS rising always terminates the frame first.

## Structure
- Package `aska_spi_pkg`:
  - `CMD_W = 8`, `RW_BIT = 7`
  - state enum `{IDLE, CMD, DATA}`
  - function for `bcnt` width: `$clog2(8+M+2)`
- Sub-module `spi_sync_edge`: 2-FF synchroniser plus rise/fall pulse outputs. Instantiate it for `SPI_CS` and `SPI_Clk`; `SPI_MOSI` uses a bare 2-FF.
- Everything else stays in one module: FSM, `bcnt`, rx/tx shift registers, register array.

## Test plan
- Write 0x00/0xAABBCCDD, 0x01/0x3377EEFF, 0x02/0xBEBECACA, 0x03/0xCAFEBABA → `regs` hold each value; one `wr_strobe` pulse per write on the matching bit; no `frame_err`.
- Write 0x03 with only 24 data bits → `frame_err` pulse; `regs[3]` unchanged; no `wr_strobe`.
- Read 0x81 after the writes → `SPI_MISO` sampled on SCK rising edges 9..40 equals 0x3377EEFF; `regs` unchanged.
- Write address 0x05 with NREG=4 → `frame_err`; no register changes. Read 0x85 → MISO returns 0x00000000 and `frame_err` pulses.
- Assert `reset` after 20 bits of a write to 0x00 → `regs` = 0, IDLE, no strobe. A following valid write succeeds.
- Run M=16, NREG=8: write 0x07/0x1234, read 0x87 → returns 0x1234. A CS pulse with no SCK → no error, no change.
